// File: rtl/debounce_multi.sv
// N-channel switch debouncer: 2-flop sync, stable-count filter, registered edge pulses and auto-repeat.
// clean follows a settled input STABLE_CYCLES+3 edges later; free-running outputs, no backpressure.
module debounce_multi #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 650000,
  parameter int HOLD_CYCLES   = 32500000,
  parameter int REPEAT_CYCLES = 6500000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] noisy,
  input  logic         repeat_en,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rpt
);

  localparam int CW     = $clog2(STABLE_CYCLES + 1);
  localparam int RC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW     = $clog2(RC_MAX + 1);

  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] HOLD_END = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RPT_END  = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] RC_ONE   = RW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          s1_q, s2_q;
    logic          new_q, new_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, fall_q, rpt_q;
    logic          rise_d;
    rpt_state_e    st_q;
    logic [RW-1:0] rc_q;

    // Any disagreement with the held sample restarts the stability count.
    always_comb begin
      new_d   = new_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      if (s2_q != new_q) begin
        new_d = s2_q;
        cnt_d = '0;
      end else if (cnt_q < CNT_SAT) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        clean_d = new_q;
      end
    end

    assign rise_d = clean_d & ~clean_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_q    <= noisy[g];
        s2_q    <= noisy[g];
        new_q   <= noisy[g];
        clean_q <= noisy[g];
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        s1_q    <= noisy[g];
        s2_q    <= s1_q;
        new_q   <= new_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= ~clean_d & clean_q;
      end
    end

    // Abort takes priority over the terminal count, so a fall cycle never carries rpt.
    always_ff @(posedge clock) begin
      if (reset) begin
        st_q  <= IDLE;
        rc_q  <= '0;
        rpt_q <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        case (st_q)
          IDLE: begin
            if (rise_d && repeat_en) begin
              st_q <= HOLD;
              rc_q <= RC_ONE;
            end
          end
          HOLD: begin
            if (!clean_d || !repeat_en) begin
              st_q <= IDLE;
              rc_q <= '0;
            end else if (rc_q == HOLD_END) begin
              st_q  <= REPEAT;
              rc_q  <= RC_ONE;
              rpt_q <= 1'b1;
            end else begin
              rc_q <= rc_q + RC_ONE;
            end
          end
          REPEAT: begin
            if (!clean_d || !repeat_en) begin
              st_q <= IDLE;
              rc_q <= '0;
            end else if (rc_q == RPT_END) begin
              rc_q  <= RC_ONE;
              rpt_q <= 1'b1;
            end else begin
              rc_q <= rc_q + RC_ONE;
            end
          end
          default: begin
            st_q <= IDLE;
            rc_q <= '0;
          end
        endcase
      end
    end

    assign clean[g] = clean_q;
    assign rise[g]  = rise_q;
    assign fall[g]  = fall_q;
    assign rpt[g]   = rpt_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random noise, checked against a
// sliding-window / elapsed-time reference model.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int ST   = 4;
  localparam int HO   = 10;
  localparam int RP   = 3;
  localparam int HMAX = 8192;

  logic         clock = 1'b0;
  logic         reset;
  logic         repeat_en;
  logic [N-1:0] noisy;
  logic [N-1:0] clean, rise, fall, rpt;

  int total = 0;
  int bad   = 0;

  debounce_multi #(
    .N(N), .STABLE_CYCLES(ST), .HOLD_CYCLES(HO), .REPEAT_CYCLES(RP)
  ) dut (
    .clock(clock), .reset(reset), .noisy(noisy), .repeat_en(repeat_en),
    .clean(clean), .rise(rise), .fall(fall), .rpt(rpt)
  );

  always #5 clock = ~clock;

  // Reference model: clean takes value v once the synchronised stream has shown v
  // for ST+2 consecutive edges; rpt fires at fixed offsets from the rise while armed.
  logic [N-1:0] nz [HMAX];
  int           cyc      = 0;
  int           rst_edge = 0;
  logic [N-1:0] exp_clean, exp_rise, exp_fall, exp_rpt;
  int           rise_at [N];
  bit           armed   [N];

  function automatic logic smp(int k, int ch);
    int idx;
    idx = (k - 2 < rst_edge) ? rst_edge : k - 2;
    return nz[idx % HMAX][ch];
  endfunction

  always @(posedge clock) begin : model
    logic [N-1:0] prev;
    logic         v;
    bit           same;
    nz[cyc % HMAX] = noisy;
    if (reset) begin
      rst_edge  = cyc;
      exp_clean = noisy;
      exp_rise  = '0;
      exp_fall  = '0;
      exp_rpt   = '0;
      for (int ch = 0; ch < N; ch++) armed[ch] = 1'b0;
    end else begin
      prev = exp_clean;
      for (int ch = 0; ch < N; ch++) begin
        if (cyc - ST - 1 >= rst_edge) begin
          v    = smp(cyc, ch);
          same = 1'b1;
          for (int k = cyc - ST - 1; k < cyc; k++)
            if (smp(k, ch) !== v) same = 1'b0;
          if (same) exp_clean[ch] = v;
        end
      end
      exp_rise = exp_clean & ~prev;
      exp_fall = ~exp_clean & prev;
      for (int ch = 0; ch < N; ch++) begin
        exp_rpt[ch] = 1'b0;
        if (exp_rise[ch]) begin
          armed[ch]   = repeat_en;
          rise_at[ch] = cyc;
        end else if (armed[ch]) begin
          if (!repeat_en || exp_fall[ch]) armed[ch] = 1'b0;
          else if (cyc - rise_at[ch] >= HO && (cyc - rise_at[ch] - HO) % RP == 0)
            exp_rpt[ch] = 1'b1;
        end
      end
    end
    cyc++;
  end

  task automatic test_reset();
    reset = 1'b1; noisy = 4'b0101; repeat_en = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({clean, rise, fall, rpt} !== {4'b0101, 12'b0}) begin
      bad++; $display("FAIL reset_during got c=%b r=%b f=%b p=%b want c=0101 r=f=p=0", clean, rise, fall, rpt);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {4'b0101, 12'b0}) begin
        bad++; $display("FAIL reset_after k=%0d got c=%b r=%b f=%b p=%b want c=0101 r=f=p=0", k, clean, rise, fall, rpt);
      end
    end
  endtask

  task automatic test_single_rise();
    int e, t;
    noisy[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    noisy[0] = 1'b1;
    e = cyc;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      t = cyc - 1;
      total++;
      if (clean[0] !== (t >= e + 7)) begin
        bad++; $display("FAIL rise0_clean edge=e+%0d got %b want %b", t - e, clean[0], (t >= e + 7));
      end
      total++;
      if (rise[0] !== (t == e + 7)) begin
        bad++; $display("FAIL rise0_pulse edge=e+%0d got %b want %b", t - e, rise[0], (t == e + 7));
      end
      total++;
      if (clean[3:1] !== 3'b010) begin
        bad++; $display("FAIL rise0_others got %b want 010", clean[3:1]);
      end
    end
  endtask

  task automatic test_bounce();
    int rises, last_e, rise_t;
    rises = 0; last_e = 0; rise_t = -1;
    for (int k = 0; k < 39; k++) begin
      if (k % 3 == 0) begin
        noisy[1] = ~noisy[1];
        last_e = cyc;
      end
      @(negedge clock);
      total++;
      if (clean[1] !== 1'b0) begin
        bad++; $display("FAIL bounce_hold k=%0d got %b want 0", k, clean[1]);
      end
      if (rise[1]) rises++;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
      if (rise[1]) begin
        rises++;
        rise_t = cyc - 1;
      end
    end
    total++;
    if (rises != 1) begin
      bad++; $display("FAIL bounce_rise_count got %0d want 1", rises);
    end
    total++;
    if (rise_t - last_e != 7) begin
      bad++; $display("FAIL bounce_rise_delay got %0d want 7", rise_t - last_e);
    end
  endtask

  task automatic test_repeat();
    int r, t, pulses, fseen;
    repeat_en = 1'b1;
    noisy[2]  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    noisy[2] = 1'b1;
    r = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (rise[2]) begin
        r = cyc - 1;
        break;
      end
    end
    total++;
    if (r < 0) begin
      bad++; $display("FAIL repeat_rise_timeout got none want rise within 15");
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      t = cyc - 1;
      total++;
      if (rpt[2] !== (t - r >= HO && (t - r - HO) % RP == 0)) begin
        bad++; $display("FAIL repeat_slot off=%0d got %b want %b", t - r, rpt[2], (t - r >= HO && (t - r - HO) % RP == 0));
      end
      if (rpt[2]) pulses++;
    end
    total++;
    if (pulses != 7) begin
      bad++; $display("FAIL repeat_count got %0d want 7", pulses);
    end
    noisy[2] = 1'b0;
    fseen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (fall[2]) fseen++;
      total++;
      if (fseen > 0 && rpt[2] !== 1'b0) begin
        bad++; $display("FAIL repeat_after_fall k=%0d got %b want 0", k, rpt[2]);
      end
    end
    total++;
    if (fseen != 1) begin
      bad++; $display("FAIL repeat_fall_count got %0d want 1", fseen);
    end
  endtask

  task automatic test_repeat_drop();
    int r, r2;
    repeat_en = 1'b1;
    noisy[2]  = 1'b1;
    r = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (rise[2]) begin
        r = cyc - 1;
        break;
      end
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == HO) begin
        total++;
        if (rpt[2] !== 1'b1 || r < 0) begin
          bad++; $display("FAIL drop_first_rpt got %b want 1", rpt[2]);
        end
      end
    end
    repeat_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      if (k == 1) repeat_en = 1'b1;
      total++;
      if (rpt[2] !== 1'b0) begin
        bad++; $display("FAIL drop_no_resume k=%0d got %b want 0", k, rpt[2]);
      end
    end
    noisy[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    noisy[2] = 1'b1;
    r2 = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (rise[2]) begin
        r2 = cyc - 1;
        break;
      end
    end
    repeat (HO) @(negedge clock);
    total++;
    if (rpt[2] !== 1'b1 || r2 < 0 || cyc - 1 - r2 != HO) begin
      bad++; $display("FAIL drop_repress_rpt got %b want 1", rpt[2]);
    end
    noisy[2] = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int rises;
    rises = 0;
    noisy[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (clean[3] !== 1'b1 || rise[3] !== 1'b0) begin
      bad++; $display("FAIL midreset_load got c=%b r=%b want c=1 r=0", clean[3], rise[3]);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (rise[3]) rises++;
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    total++;
    if (rises != 0 || clean[3] !== 1'b1) begin
      bad++; $display("FAIL midreset_after got rises=%0d c=%b want rises=0 c=1", rises, clean[3]);
    end
  endtask

  task automatic test_random();
    int odds;
    for (int k = 0; k < 1500; k++) begin
      odds = ((k / 50) % 2 == 1) ? 3 : 40;
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, odds - 1) == 0) noisy[ch] = ~noisy[ch];
      if ($urandom_range(0, 149) == 0) repeat_en = ~repeat_en;
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clock);
      total++;
      if ({clean, rise, fall, rpt} !== {exp_clean, exp_rise, exp_fall, exp_rpt}) begin
        bad++; $display("FAIL model@%0d got %b %b %b %b want %b %b %b %b", cyc - 1, clean, rise, fall, rpt, exp_clean, exp_rise, exp_fall, exp_rpt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_bounce();
    test_repeat();
    test_repeat_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL have parameter N, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter STABLE_CYCLES, default 650000: consecutive stable synchronised samples required before clean changes (>=1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 32500000: cycles from rise pulse to first auto-repeat pulse (>=1).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 6500000: cycles between subsequent auto-repeat pulses (>=1).
REQ-005 SHALL have port clock  input  1  single clock for all logic.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port noisy  input  N  raw asynchronous switch inputs, bit i = channel i.
REQ-008 SHALL have port repeat_en  input  1  global auto-repeat enable.
REQ-009 SHALL have port clean  output  N  debounced level per channel, registered.
REQ-010 SHALL have port rise  output  N  one-cycle pulse when clean[i] goes 0->1.
REQ-011 SHALL have port fall  output  N  one-cycle pulse when clean[i] goes 1->0.
REQ-012 SHALL have port rpt  output  N  one-cycle auto-repeat pulse while clean[i] held high.

Function
REQ-013 SHALL pass each noisy[i] through a 2-flop synchroniser (s1, s2); s2 feeds the debouncer; channels fully independent.
REQ-014 SHALL keep per channel a sample register new[i] and counter cnt[i] of width clog2(STABLE_CYCLES+1).
REQ-015 SHALL, when s2[i] != new[i]: load new[i] <= s2[i], cnt[i] <= 0, clean unchanged.
REQ-016 SHALL, when s2[i] == new[i] and cnt[i] < STABLE_CYCLES: cnt[i] <= cnt[i]+1.
REQ-017 SHALL, when s2[i] == new[i] and cnt[i] == STABLE_CYCLES: clean[i] <= new[i]; cnt[i] saturates (holds).
REQ-018 SHALL give latency: input change settled before edge e -> clean[i] updates at edge e+STABLE_CYCLES+3; any glitch restarts the count.
REQ-019 SHALL assert rise[i]/fall[i] registered, high exactly in the cycle where clean[i] first shows the new value; never both in one cycle.
REQ-020 SHALL implement per-channel auto-repeat FSM with states IDLE, HOLD, REPEAT and counter rc[i] of width clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1).
REQ-021 SHALL transition IDLE->HOLD (rc<=1) in the rise[i] cycle if repeat_en=1; otherwise stay IDLE.
REQ-022 SHALL in HOLD increment rc each cycle; when rc == HOLD_CYCLES pulse rpt[i] next cycle, go REPEAT, rc<=1; first rpt occurs HOLD_CYCLES cycles after rise[i].
REQ-023 SHALL in REPEAT increment rc; when rc == REPEAT_CYCLES pulse rpt[i], rc<=1; rpt spacing exactly REPEAT_CYCLES cycles.
REQ-024 SHALL return to IDLE (rc<=0, no rpt) from HOLD/REPEAT when clean[i] falls or repeat_en=0; fall[i] cycle never carries rpt[i].
REQ-025 SHALL not resume repeat when repeat_en reasserts mid-press; a new rise[i] is required.

Reset
REQ-026 SHALL on reset load s1, s2, new, clean <= noisy (raw, unsynchronised), cnt <= 0, FSM <= IDLE, rc <= 0.
REQ-027 SHALL hold rise, fall, rpt at 0 during and in the cycle after reset; no edge pulse is generated by reset itself.
REQ-028 SHALL take effect on any cycle, aborting in-progress counts and repeat sequences.

Verification (N=4, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3)
REQ-029 Reset with noisy=4'b0101 -> clean=4'b0101, rise=fall=rpt=0 after reset released.
REQ-030 noisy[0] 0->1 clean before edge e, held -> clean[0]=1 and rise[0]=1 for one cycle at edge e+7; other channels unchanged.
REQ-031 noisy[1] toggles every 3 cycles for 40 cycles then stays 1 -> clean[1] unchanged during bounce, rises 7 edges after last toggle, exactly one rise[1].
REQ-032 repeat_en=1, channel 2 pressed and held 30 cycles past rise -> rpt[2] pulses at rise+10, +13, +16, ... ; release -> fall[2], rpt stops.
REQ-033 Repeat running, repeat_en dropped then raised while held -> rpt stops immediately, does not resume until release and re-press.
REQ-034 Reset asserted mid-debounce (cnt=2) with noisy[3]=1, clean[3]=0 -> clean[3]=1 next cycle, no rise[3] pulse.
